bypass_ctrl: RTL and testbench
==============================

# bypass_ctrl

Tracks destination registers of in-flight instructions in the X, M and W stages of the five-stage pipeline. Drives the 2-bit selects of the two 32-bit four-input operand multiplexers that feed the ALU. Detects load-use hazards and issues the D-stage stall. Sits between decode and the execute-stage operand multiplexers.

## Interface
- REG_BITS, 5, register-index width (32 architectural registers; r0 reads zero)
- CNT_WIDTH, 16, width of stall-cycle counter
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- freeze  in  1  multdiv busy; holds every pipeline register and the counter
- flush  in  1  taken branch/jump resolved in X; D→X slot becomes a bubble
- d_valid  in  1  D stage holds a real instruction
- d_rs1, d_rs2  in  REG_BITS  source register indices of D instruction
- d_rd  in  REG_BITS  destination index of D instruction
- d_we  in  1  D instruction writes d_rd
- d_is_load  in  1  D instruction is a load
- sel_a, sel_b  out  2  operand-mux selects for instruction in X
- load_stall  out  1  hold F and D, insert bubble into X this cycle
- stall_count  out  CNT_WIDTH  saturating count of load_stall cycles

## Operation
- Per-stage record for X, M, W: valid, rd, we, is_load; X also holds rs1, rs2. All bits 0 after reset.
- Select encoding, identical for sel_a (rs1) and sel_b (rs2):
  - 2'b11: source index is 0 → constant zero (highest priority)
  - 2'b01: M valid, M.we, M.rd == source, M not a load → X/M ALU result
  - 2'b10: W valid, W.we, W.rd == source → M/W writeback value
  - 2'b00: otherwise → value latched from regfile at D/X
  - M match beats W match (youngest producer wins).
- Writes to r0 never create a match (rd==0 treated as we=0).
- load_stall = X.valid & X.is_load & X.we & X.rd≠0 & d_valid & (X.rd==d_rs1 | X.rd==d_rs2), gated low while freeze=1.
- Advance, per clock edge, in priority order:
  1. reset: all records and stall_count cleared.
  2. freeze: all records and stall_count hold.
  3. flush: M←X, W←M, X←bubble (valid=0). Overrides load_stall.
  4. load_stall: M←X, W←M, X←bubble; stall_count += 1, saturating at all-ones.
  5. otherwise: W←M, M←X, X←D fields (valid=d_valid).
- Bubble: valid=0, we=0, is_load=0, indices 0.

## Timing
- Reset values: sel_a=sel_b=2'b11 (X indices 0), load_stall=0, stall_count=0.
- sel_a, sel_b, load_stall combinational from registered state plus D inputs; no added latency.
- Instruction enters X one edge after it is presented in D unstalled.
- Back-to-back dependent ALU ops: consumer in X sees 2'b01 in its first X cycle.
- Load then dependent op: exactly one stall cycle; consumer then sees 2'b10.
- Producer two ahead: 2'b10. Three or more ahead: 2'b00 (regfile write-before-read).
- flush and load_stall high together: flush wins, counter does not increment.
- freeze during a stall: load_stall forced 0; state resumes unchanged when freeze drops.
- reset asserted mid-stall: next cycle all bubbles, no pending stall.

## Structure
- Shared package: select encodings SEL_REG=2'b00, SEL_XM=2'b01, SEL_MW=2'b10, SEL_ZERO=2'b11; stage-record type (valid, rd, we, is_load).
- One sub-module: bypass_match — combinational per-operand select priority logic, instantiated twice (rs1, rs2).
- Stage records and counter are local to bypass_ctrl.

## Test plan
- Reset, then idle: sel_a=sel_b=2'b11, load_stall=0, stall_count=0.
- add r3 then sub r4,r3,r5 → with sub in X: sel_a=2'b01, sel_b=2'b00.
- lw r6 then add r7,r6,r6 → load_stall=1 one cycle, stall_count=1; next X cycle sel_a=sel_b=2'b10.
- add r0,r1,r2 then add r8,r0,r0 → sel_a=sel_b=2'b11, no stall.
- lw r9 then use r9 with flush=1 same cycle → no stall, stall_count stays 0, X becomes bubble.
- freeze=1 for 10 cycles mid-sequence → selects and stall_count constant; after release, sequence matches unfrozen run.

Source files
------------

// File: rtl/bypass_ctrl_pkg.sv
// Shared definitions for the operand-bypass controller: select codes and
// the per-stage destination record carried down X, M and W.
package bypass_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] SEL_REG  = 2'b00;  // value latched from regfile at D/X
  localparam logic [1:0] SEL_XM   = 2'b01;  // X/M ALU result
  localparam logic [1:0] SEL_MW   = 2'b10;  // M/W writeback value
  localparam logic [1:0] SEL_ZERO = 2'b11;  // constant zero (r0)

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             is_load;
  } stage_t;

endpackage

// File: rtl/bypass_ctrl_if.sv
// Decode-side bundle into the bypass controller and the selects/stall back.
interface bypass_ctrl_if #(
  parameter int REG_BITS  = 5,
  parameter int CNT_WIDTH = 16
);
  logic                 freeze;
  logic                 flush;
  logic                 d_valid;
  logic [REG_BITS-1:0]  d_rs1;
  logic [REG_BITS-1:0]  d_rs2;
  logic [REG_BITS-1:0]  d_rd;
  logic                 d_we;
  logic                 d_is_load;
  logic [1:0]           sel_a;
  logic [1:0]           sel_b;
  logic                 load_stall;
  logic [CNT_WIDTH-1:0] stall_count;

  modport master (
    output freeze, flush, d_valid, d_rs1, d_rs2, d_rd, d_we, d_is_load,
    input  sel_a, sel_b, load_stall, stall_count
  );

  modport slave (
    input  freeze, flush, d_valid, d_rs1, d_rs2, d_rd, d_we, d_is_load,
    output sel_a, sel_b, load_stall, stall_count
  );
endinterface

// File: rtl/bypass_match.sv
// Per-operand select priority: r0 first, then youngest producer (M) over W.
module bypass_match
  import bypass_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  stage_t           m,
  input  stage_t           w,
  output logic [1:0]       sel
);
  logic m_hit, w_hit;

  // A write to r0 never produces a match; a load in M has no data yet.
  assign m_hit = m.valid & m.we & (m.rd != '0) & (m.rd == src) & ~m.is_load;
  assign w_hit = w.valid & w.we & (w.rd != '0) & (w.rd == src);

  // Priority encode the mux select.
  always_comb begin
    sel = SEL_REG;
    if (src == '0)  sel = SEL_ZERO;
    else if (m_hit) sel = SEL_XM;
    else if (w_hit) sel = SEL_MW;
  end
endmodule

// File: rtl/bypass_ctrl.sv
// Tracks X/M/W destinations, drives ALU operand selects and the load-use stall.
module bypass_ctrl
  import bypass_ctrl_pkg::*;
#(
  parameter int REG_BITS  = REG_W,
  parameter int CNT_WIDTH = 16
) (
  input logic         clock,
  input logic         reset,
  bypass_ctrl_if.slave bus
);
  stage_t               x, m, w;
  logic [REG_W-1:0]     x_rs1, x_rs2;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 load_stall;

  bypass_match u_match_a (.src(x_rs1), .m(m), .w(w), .sel(bus.sel_a));
  bypass_match u_match_b (.src(x_rs2), .m(m), .w(w), .sel(bus.sel_b));

  // Load in X feeding the instruction in D: hold F/D one cycle.
  always_comb begin
    load_stall = ~bus.freeze & x.valid & x.is_load & x.we & (x.rd != '0) &
                 bus.d_valid & ((x.rd == bus.d_rs1) | (x.rd == bus.d_rs2));
  end

  assign bus.load_stall  = load_stall;
  assign bus.stall_count = cnt;

  // Pipeline advance: reset > freeze > flush > load_stall > normal.
  always_ff @(posedge clock) begin
    if (reset) begin
      x     <= '0;
      m     <= '0;
      w     <= '0;
      x_rs1 <= '0;
      x_rs2 <= '0;
      cnt   <= '0;
    end else if (!bus.freeze) begin
      w <= m;
      m <= x;
      if (bus.flush || load_stall) begin
        x     <= '0;
        x_rs1 <= '0;
        x_rs2 <= '0;
        // A flushed stall never happened, so it is not counted.
        if (!bus.flush && cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
      end else begin
        x.valid   <= bus.d_valid;
        x.rd      <= bus.d_rd;
        x.we      <= bus.d_we;
        x.is_load <= bus.d_is_load;
        x_rs1     <= bus.d_rs1;
        x_rs2     <= bus.d_rs2;
      end
    end
  end
endmodule

// File: tb/tb_bypass_ctrl.sv
// Randomized + directed bench for bypass_ctrl against a queue-style pipeline model.
module tb_bypass_ctrl;
  localparam int RB = 5;
  localparam int CW = 3;  // narrow counter so saturation is reachable

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bypass_ctrl_if #(.REG_BITS(RB), .CNT_WIDTH(CW)) bus ();
  bypass_ctrl #(.REG_BITS(RB), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );

  typedef struct {
    bit v; int rd; bit we; bit ld; int rs1; int rs2;
  } rec_t;

  rec_t pipe[3];  // 0 = X, 1 = M, 2 = W
  int   cnt_m;
  int   npass = 0, ntot = 0;

  task automatic chk(input string tag, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Select from the forwarding rules: r0, youngest non-load writer, older writer, regfile.
  function automatic int exp_sel(input int src);
    if (src == 0) return 3;
    if (pipe[1].v && pipe[1].we && pipe[1].rd == src && !pipe[1].ld) return 1;
    if (pipe[2].v && pipe[2].we && pipe[2].rd == src) return 2;
    return 0;
  endfunction

  // One cycle: present D, check combinational outputs, clock, update the model.
  task automatic step(input bit v, input int rs1, input int rs2, input int rd,
                      input bit we, input bit ld, input bit fz, input bit fl,
                      input bit rst);
    bit   ls;
    rec_t nx;
    @(negedge clock);
    reset         = rst;
    bus.freeze    = fz;
    bus.flush     = fl;
    bus.d_valid   = v;
    bus.d_rs1     = RB'(rs1);
    bus.d_rs2     = RB'(rs2);
    bus.d_rd      = RB'(rd);
    bus.d_we      = we;
    bus.d_is_load = ld;
    #1;
    ls = !fz && pipe[0].v && pipe[0].ld && pipe[0].we && pipe[0].rd != 0 && v &&
         (pipe[0].rd == rs1 || pipe[0].rd == rs2);
    chk("sel_a", int'(bus.sel_a), exp_sel(pipe[0].rs1));
    chk("sel_b", int'(bus.sel_b), exp_sel(pipe[0].rs2));
    chk("load_stall", int'(bus.load_stall), int'(ls));
    chk("stall_count", int'(bus.stall_count), cnt_m);
    @(posedge clock);
    #1;
    if (rst) begin
      pipe[0] = '{default: 0}; pipe[1] = '{default: 0}; pipe[2] = '{default: 0};
      cnt_m = 0;
    end else if (!fz) begin
      nx = '{v: v, rd: rd, we: we, ld: ld, rs1: rs1, rs2: rs2};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (fl || ls) begin
        pipe[0] = '{default: 0};
        if (!fl && cnt_m != (1 << CW) - 1) cnt_m++;
      end else pipe[0] = nx;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    pipe[0] = '{default: 0}; pipe[1] = '{default: 0}; pipe[2] = '{default: 0};
    cnt_m = 0;
    // Reset then idle: zero selects, no stall, zero count.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // add r3,r1,r2 ; sub r4,r3,r5 -> sub in X sees X/M for rs1.
    step(1, 1, 2, 3, 1, 0, 0, 0, 0);
    step(1, 3, 5, 4, 1, 0, 0, 0, 0);
    chk("dep_alu_sel_a", int'(bus.sel_a), 1);
    chk("dep_alu_sel_b", int'(bus.sel_b), 0);
    idle(3);

    // Producer two ahead -> M/W, three ahead -> regfile.
    step(1, 1, 2, 10, 1, 0, 0, 0, 0);
    step(1, 1, 2, 11, 1, 0, 0, 0, 0);
    step(1, 10, 2, 12, 1, 0, 0, 0, 0);
    chk("two_ahead", int'(bus.sel_a), 2);
    step(1, 1, 2, 13, 1, 0, 0, 0, 0);
    step(1, 10, 11, 14, 1, 0, 0, 0, 0);
    chk("three_ahead", int'(bus.sel_a), 0);
    idle(3);

    // lw r6 ; add r7,r6,r6 -> one stall cycle, then M/W on both.
    step(1, 1, 0, 6, 1, 1, 0, 0, 0);
    step(1, 6, 6, 7, 1, 0, 0, 0, 0);
    chk("load_use_cnt", int'(bus.stall_count), 1);
    step(1, 6, 6, 7, 1, 0, 0, 0, 0);
    chk("load_use_sel_a", int'(bus.sel_a), 2);
    chk("load_use_sel_b", int'(bus.sel_b), 2);
    idle(3);

    // add r0,r1,r2 ; add r8,r0,r0 -> zero selects.
    step(1, 1, 2, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 8, 1, 0, 0, 0, 0);
    chk("r0_sel_a", int'(bus.sel_a), 3);
    chk("r0_sel_b", int'(bus.sel_b), 3);
    idle(3);

    // lw r9 ; use with flush -> bubble in X, count unchanged.
    step(1, 1, 0, 9, 1, 1, 0, 0, 0);
    step(1, 9, 2, 15, 1, 0, 0, 1, 0);
    chk("flush_cnt", int'(bus.stall_count), 1);
    chk("flush_bubble", int'(bus.sel_a), 3);
    idle(3);

    // Freeze during a pending load-use stall, then release.
    step(1, 1, 0, 6, 1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 6, 2, 7, 1, 0, 1, 0, 0);
    chk("freeze_cnt", int'(bus.stall_count), 1);
    step(1, 6, 2, 7, 1, 0, 0, 0, 0);
    chk("unfreeze_cnt", int'(bus.stall_count), 2);
    idle(3);

    // Reset while a stall is pending clears everything.
    step(1, 1, 0, 6, 1, 1, 0, 0, 0);
    step(1, 6, 2, 7, 1, 0, 0, 0, 1);
    chk("rst_cnt", int'(bus.stall_count), 0);
    chk("rst_sel", int'(bus.sel_a), 3);

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
